microwave_cook_ctrl: RTL and testbench
======================================

Name: microwave_cook_ctrl

Overview:
- Cook-cycle controller for the microwave oven design.
- Consumes the square-wave 1 Hz output of the existing clock divider as a time base.
- Holds the cook time as BCD MM:SS and accepts time-entry, start and cancel pulses plus the door switch.
- Sequences magnetron, lamp and buzzer through an IDLE/COOK/PAUSE/DONE state machine.

Parameters:
- BEEP_TICKS, 3, number of 1 Hz ticks the buzzer stays on in DONE (range 1..15).
- MAX_MIN_TENS, 9, saturation value of the minutes tens digit (99:59 maximum at default).

Ports:
- clock_in  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- tick_in  input  1  1 Hz square wave from the clock divider; asynchronous to control logic, edge-detected internally
- btn_add_min  input  1  one-cycle pulse, add 1 minute
- btn_add_10s  input  1  one-cycle pulse, add 10 seconds
- btn_start  input  1  one-cycle pulse, start/resume
- btn_cancel  input  1  one-cycle pulse, pause/clear
- door_open  input  1  level, 1 = door open (already synchronous)
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD remaining time
- state  output  2  0=IDLE 1=COOK 2=PAUSE 3=DONE
- magnetron_on  output  1  heater enable
- lamp_on  output  1  cavity lamp
- buzzer  output  1  alarm

Behaviour:
- Clock and reset: one clock, clock_in. Reset is asynchronous, active-low on reset_n.
- Reset values: state=IDLE, all BCD digits 0, buzzer=0, beep counter 0, sync flops 0.
- Tick detection:
  - tick_in passes through a 2-flop synchronizer plus a history flop.
  - tick_p = sync2 & ~hist.
  - tick_p is high for exactly one cycle, 3 clock_in cycles after tick_in rises.
  - Falling edges are ignored.
- BCD arithmetic:
  - Digits stay legal: sec_tens 0..5, others 0..9.
  - add_min: minutes +1; saturates at MAX_MIN_TENS:9 (seconds unchanged).
  - add_10s: sec_tens +1; 5→0 carries into minutes. If the minutes carry would exceed maximum, result = max:59.
  - Decrement borrows 0→9 (ones) and 0→5 (sec_tens).
- Priority each cycle: cancel > door_open > start > add > tick_p.
  - The highest applicable event acts; lower events that cycle are dropped.
  - A tick coinciding with an add is lost.
- IDLE:
  - adds modify time.
  - start with time≠00:00 and door closed → COOK.
  - start with time=00:00 or door open is ignored.
  - cancel clears time to 00:00.
- COOK:
  - tick_p decrements. Decrement from 00:01 → time 00:00 and state DONE in the same cycle.
  - adds allowed.
  - door_open or cancel → PAUSE with no decrement.
  - start ignored.
- PAUSE:
  - time frozen; ticks ignored; adds allowed.
  - start with door closed → COOK.
  - cancel → IDLE with time cleared to 00:00.
- DONE:
  - buzzer=1; beep counter counts tick_p.
  - After BEEP_TICKS ticks → IDLE, buzzer=0, counter cleared.
  - cancel or door_open → IDLE immediately, buzzer=0.
  - adds and start ignored.
- Outputs:
  - magnetron_on = (state==COOK) & ~door_open, combinational. Guarantees zero-cycle cutoff when the door opens.
  - lamp_on = (state==COOK) | door_open.
  - buzzer is registered.
  - BCD digits and state are registered.
- Reset mid-cook: reset_n low immediately forces IDLE, magnetron_on=0, time 00:00. No resume after reset release.

Test Plan:
1. From reset: add_10s ×3, start, run 30 tick_in periods → digits count 00:30…00:01. DONE coincides with 00:00, buzzer=1 for 3 ticks, then IDLE. magnetron_on high only while COOK.
2. 00:50 + add_10s → 01:00. Set 99:50, add_10s → 99:59. add_min at 99:59 stays 99:59. From 00:00, one tick in COOK is never reachable (start ignored).
3. COOK at 01:00:
   - door_open=1 → magnetron_on=0 same cycle, state PAUSE next cycle, time frozen across 5 ticks.
   - Close door, start → COOK, countdown resumes from 01:00.
4. COOK at 00:45:
   - cancel → PAUSE at 00:45.
   - cancel again → IDLE 00:00.
   - start with door open in IDLE → ignored.
5. Align btn_add_10s with tick_p at 00:20 in COOK → 00:30 (tick dropped). Align btn_cancel with tick_p → PAUSE at unchanged time.
6. Assert reset_n low mid-COOK at 02:13 asynchronously (between clock edges) → outputs immediately IDLE/00:00/magnetron_on=0/buzzer=0.

Source files
------------

// File: rtl/microwave_cook_ctrl_if.sv
// Control and display bundle between the oven front panel and the cook-cycle
// controller. The front panel (master) drives the buttons, the door switch and
// the 1 Hz tick. The controller (slave) drives the BCD time, the state code
// and the actuator enables.
interface microwave_cook_ctrl_if;
  logic       tick_in;
  logic       btn_add_min;
  logic       btn_add_10s;
  logic       btn_start;
  logic       btn_cancel;
  logic       door_open;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] state;
  logic       magnetron_on;
  logic       lamp_on;
  logic       buzzer;

  modport master (
    output tick_in, btn_add_min, btn_add_10s, btn_start, btn_cancel, door_open,
    input  min_tens, min_ones, sec_tens, sec_ones, state,
    input  magnetron_on, lamp_on, buzzer
  );

  modport slave (
    input  tick_in, btn_add_min, btn_add_10s, btn_start, btn_cancel, door_open,
    output min_tens, min_ones, sec_tens, sec_ones, state,
    output magnetron_on, lamp_on, buzzer
  );
endinterface

// File: rtl/microwave_cook_ctrl.sv
// Cook-cycle controller: keeps the remaining time as BCD MM:SS, counts it down
// on each rising edge of the 1 Hz tick, and sequences magnetron, lamp and
// buzzer through IDLE/COOK/PAUSE/DONE. The magnetron enable is gated by the
// door switch combinationally so that opening the door cuts the heater off in
// the same cycle, without waiting for the state register.
module microwave_cook_ctrl #(
  parameter int BEEP_TICKS   = 3,
  parameter int MAX_MIN_TENS = 9
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  microwave_cook_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] MAX_MT    = 4'(MAX_MIN_TENS);
  localparam logic [3:0] BEEP_LAST = 4'(BEEP_TICKS - 1);

  state_t     state_q;
  logic [3:0] minTens_q;
  logic [3:0] minOnes_q;
  logic [3:0] secTens_q;
  logic [3:0] secOnes_q;
  logic [3:0] beepCnt_q;
  logic       buzzer_q;
  logic       sync1_q;
  logic       sync2_q;
  logic       hist_q;

  logic        tickP;
  logic [15:0] timeNow;
  logic [15:0] timeAddMin_d;
  logic [15:0] timeAdd10s_d;
  logic [15:0] timeDec_d;
  logic        timeIsZero;
  logic        timeIsOne;

  assign timeNow    = {minTens_q, minOnes_q, secTens_q, secOnes_q};
  assign timeIsZero = (timeNow == 16'h0000);
  assign timeIsOne  = (timeNow == 16'h0001);
  assign tickP      = sync2_q & ~hist_q;

  // Bring the free-running 1 Hz square wave into the clock domain and keep
  // one extra stage of history so only its rising edge produces a pulse.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= bus.tick_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // One minute up, carrying ones into tens; holds once the top value is reached.
  always_comb begin
    timeAddMin_d = timeNow;
    if (minOnes_q != 4'd9) begin
      timeAddMin_d[11:8] = minOnes_q + 4'd1;
    end else if (minTens_q != MAX_MT) begin
      timeAddMin_d[15:12] = minTens_q + 4'd1;
      timeAddMin_d[11:8]  = 4'd0;
    end
  end

  // Ten seconds up; a carry out of the minutes pins the display at max:59.
  always_comb begin
    timeAdd10s_d = timeNow;
    if (secTens_q != 4'd5) begin
      timeAdd10s_d[7:4] = secTens_q + 4'd1;
    end else if (minOnes_q != 4'd9) begin
      timeAdd10s_d[11:8] = minOnes_q + 4'd1;
      timeAdd10s_d[7:4]  = 4'd0;
    end else if (minTens_q != MAX_MT) begin
      timeAdd10s_d[15:12] = minTens_q + 4'd1;
      timeAdd10s_d[11:8]  = 4'd0;
      timeAdd10s_d[7:4]   = 4'd0;
    end else begin
      timeAdd10s_d[7:4] = 4'd5;
      timeAdd10s_d[3:0] = 4'd9;
    end
  end

  // One second down with BCD borrows; only used when the time is nonzero.
  always_comb begin
    timeDec_d = timeNow;
    if (secOnes_q != 4'd0) begin
      timeDec_d[3:0] = secOnes_q - 4'd1;
    end else begin
      timeDec_d[3:0] = 4'd9;
      if (secTens_q != 4'd0) begin
        timeDec_d[7:4] = secTens_q - 4'd1;
      end else begin
        timeDec_d[7:4] = 4'd5;
        if (minOnes_q != 4'd0) begin
          timeDec_d[11:8] = minOnes_q - 4'd1;
        end else begin
          timeDec_d[11:8]  = 4'd9;
          timeDec_d[15:12] = minTens_q - 4'd1;
        end
      end
    end
  end

  // Main sequencer: one event acts per cycle in the order
  // cancel, door, start, add, tick; whatever loses is dropped.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      {minTens_q, minOnes_q, secTens_q, secOnes_q} <= 16'h0000;
      beepCnt_q <= 4'd0;
      buzzer_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.btn_cancel) begin
            {minTens_q, minOnes_q, secTens_q, secOnes_q} <= 16'h0000;
          end else if (bus.btn_start) begin
            if (!bus.door_open && !timeIsZero) begin
              state_q <= COOK;
            end
          end else if (bus.btn_add_min) begin
            {minTens_q, minOnes_q, secTens_q, secOnes_q} <= timeAddMin_d;
          end else if (bus.btn_add_10s) begin
            {minTens_q, minOnes_q, secTens_q, secOnes_q} <= timeAdd10s_d;
          end
        end

        COOK: begin
          if (bus.btn_cancel || bus.door_open) begin
            state_q <= PAUSE;
          end else if (bus.btn_add_min) begin
            {minTens_q, minOnes_q, secTens_q, secOnes_q} <= timeAddMin_d;
          end else if (bus.btn_add_10s) begin
            {minTens_q, minOnes_q, secTens_q, secOnes_q} <= timeAdd10s_d;
          end else if (tickP) begin
            if (timeIsOne || timeIsZero) begin
              {minTens_q, minOnes_q, secTens_q, secOnes_q} <= 16'h0000;
              state_q   <= DONE;
              buzzer_q  <= 1'b1;
              beepCnt_q <= 4'd0;
            end else begin
              {minTens_q, minOnes_q, secTens_q, secOnes_q} <= timeDec_d;
            end
          end
        end

        PAUSE: begin
          if (bus.btn_cancel) begin
            state_q <= IDLE;
            {minTens_q, minOnes_q, secTens_q, secOnes_q} <= 16'h0000;
          end else if (bus.btn_start) begin
            if (!bus.door_open) begin
              state_q <= COOK;
            end
          end else if (bus.btn_add_min) begin
            {minTens_q, minOnes_q, secTens_q, secOnes_q} <= timeAddMin_d;
          end else if (bus.btn_add_10s) begin
            {minTens_q, minOnes_q, secTens_q, secOnes_q} <= timeAdd10s_d;
          end
        end

        DONE: begin
          if (bus.btn_cancel || bus.door_open) begin
            state_q   <= IDLE;
            buzzer_q  <= 1'b0;
            beepCnt_q <= 4'd0;
          end else if (tickP) begin
            if (beepCnt_q == BEEP_LAST) begin
              state_q   <= IDLE;
              buzzer_q  <= 1'b0;
              beepCnt_q <= 4'd0;
            end else begin
              beepCnt_q <= beepCnt_q + 4'd1;
            end
          end
        end

        default: begin
          state_q  <= IDLE;
          buzzer_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state        = state_q;
  assign bus.min_tens     = minTens_q;
  assign bus.min_ones     = minOnes_q;
  assign bus.sec_tens     = secTens_q;
  assign bus.sec_ones     = secOnes_q;
  assign bus.buzzer       = buzzer_q;
  assign bus.magnetron_on = (state_q == COOK) & ~bus.door_open;
  assign bus.lamp_on      = (state_q == COOK) | bus.door_open;

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// Directed bench for the cook-cycle controller: countdown to DONE and beeps,
// BCD carries and saturation, door/cancel pause and resume, events colliding
// with a tick, and asynchronous reset in the middle of cooking.
module tb_microwave_cook_ctrl;

  localparam int BTN_MIN    = 0;
  localparam int BTN_10S    = 1;
  localparam int BTN_START  = 2;
  localparam int BTN_CANCEL = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COOK  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic        clock_in;
  logic        reset_n;
  logic [15:0] timeBcd;
  int          checkCount;
  int          errorCount;

  microwave_cook_ctrl_if bus ();

  microwave_cook_ctrl #(
    .BEEP_TICKS   (3),
    .MAX_MIN_TENS (9)
  ) dut (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  assign timeBcd = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};

  // 100 MHz-style free-running system clock.
  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  // Expected MM:SS display for a count of seconds.
  function automatic logic [15:0] toBcd(input int secs);
    int m;
    int s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic setButton(input int which, input logic val);
    case (which)
      BTN_MIN:    bus.btn_add_min = val;
      BTN_10S:    bus.btn_add_10s = val;
      BTN_START:  bus.btn_start   = val;
      default:    bus.btn_cancel  = val;
    endcase
  endtask

  // One-cycle button pulse; returns on the falling edge after it was consumed.
  task automatic applyStimulus(input int which);
    @(negedge clock_in);
    setButton(which, 1'b1);
    @(negedge clock_in);
    setButton(which, 1'b0);
  endtask

  // One full 1 Hz period, compressed to 8 clocks; its rising edge acts
  // on the third rising clock edge after tick_in goes high.
  task automatic applyTick();
    @(negedge clock_in);
    bus.tick_in = 1'b1;
    repeat (4) @(negedge clock_in);
    bus.tick_in = 1'b0;
    repeat (4) @(negedge clock_in);
  endtask

  // Tick period with a button pulse landing on the same cycle as the tick pulse.
  task automatic applyTickWithButton(input int which);
    @(negedge clock_in);
    bus.tick_in = 1'b1;
    @(negedge clock_in);
    @(negedge clock_in);
    setButton(which, 1'b1);
    @(negedge clock_in);
    setButton(which, 1'b0);
    @(negedge clock_in);
    bus.tick_in = 1'b0;
    repeat (4) @(negedge clock_in);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock_in);
    checkCount++;
    if (bus.state !== S_IDLE) begin
      errorCount++;
      $display("[TB] FAIL reset_state got=%0d want=%0d", bus.state, S_IDLE);
    end
    checkCount++;
    if (timeBcd !== 16'h0000 || bus.buzzer !== 1'b0 || bus.magnetron_on !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_outputs got time=%h buz=%b mag=%b want 0000/0/0",
               timeBcd, bus.buzzer, bus.magnetron_on);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock_in);
  endtask

  task automatic test_countdown();
    logic [15:0] want;
    repeat (3) applyStimulus(BTN_10S);
    checkCount++;
    if (timeBcd !== 16'h0030) begin
      errorCount++;
      $display("[TB] FAIL cd_setup got=%h want=0030", timeBcd);
    end
    applyStimulus(BTN_START);
    checkCount++;
    if (bus.state !== S_COOK || bus.magnetron_on !== 1'b1 || bus.lamp_on !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL cd_start got st=%0d mag=%b lamp=%b want 1/1/1",
               bus.state, bus.magnetron_on, bus.lamp_on);
    end
    for (int k = 1; k <= 30; k++) begin
      applyTick();
      want = toBcd(30 - k);
      checkCount++;
      if (timeBcd !== want) begin
        errorCount++;
        $display("[TB] FAIL cd_time_%0d got=%h want=%h", k, timeBcd, want);
      end
      if (k < 30) begin
        checkCount++;
        if (bus.state !== S_COOK || bus.magnetron_on !== 1'b1) begin
          errorCount++;
          $display("[TB] FAIL cd_cook_%0d got st=%0d mag=%b want 1/1", k, bus.state, bus.magnetron_on);
        end
      end
    end
    checkCount++;
    if (bus.state !== S_DONE || bus.buzzer !== 1'b1 || bus.magnetron_on !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL cd_done got st=%0d buz=%b mag=%b want 3/1/0",
               bus.state, bus.buzzer, bus.magnetron_on);
    end
    for (int b = 1; b <= 3; b++) begin
      applyTick();
      checkCount++;
      if (b < 3) begin
        if (bus.state !== S_DONE || bus.buzzer !== 1'b1) begin
          errorCount++;
          $display("[TB] FAIL beep_%0d got st=%0d buz=%b want 3/1", b, bus.state, bus.buzzer);
        end
      end else begin
        if (bus.state !== S_IDLE || bus.buzzer !== 1'b0) begin
          errorCount++;
          $display("[TB] FAIL beep_end got st=%0d buz=%b want 0/0", bus.state, bus.buzzer);
        end
      end
    end
  endtask

  task automatic test_bcd_limits();
    repeat (5) applyStimulus(BTN_10S);
    checkCount++;
    if (timeBcd !== 16'h0050) begin
      errorCount++;
      $display("[TB] FAIL add_0050 got=%h want=0050", timeBcd);
    end
    applyStimulus(BTN_10S);
    checkCount++;
    if (timeBcd !== 16'h0100) begin
      errorCount++;
      $display("[TB] FAIL add_carry got=%h want=0100", timeBcd);
    end
    applyStimulus(BTN_CANCEL);
    for (int i = 1; i <= 99; i++) begin
      applyStimulus(BTN_MIN);
      if (i == 10) begin
        checkCount++;
        if (timeBcd !== 16'h1000) begin
          errorCount++;
          $display("[TB] FAIL add_min_10 got=%h want=1000", timeBcd);
        end
      end
    end
    repeat (5) applyStimulus(BTN_10S);
    checkCount++;
    if (timeBcd !== 16'h9950) begin
      errorCount++;
      $display("[TB] FAIL set_9950 got=%h want=9950", timeBcd);
    end
    applyStimulus(BTN_10S);
    checkCount++;
    if (timeBcd !== 16'h9959) begin
      errorCount++;
      $display("[TB] FAIL sat_10s got=%h want=9959", timeBcd);
    end
    applyStimulus(BTN_MIN);
    checkCount++;
    if (timeBcd !== 16'h9959) begin
      errorCount++;
      $display("[TB] FAIL sat_min got=%h want=9959", timeBcd);
    end
    applyStimulus(BTN_CANCEL);
    checkCount++;
    if (timeBcd !== 16'h0000) begin
      errorCount++;
      $display("[TB] FAIL idle_clear got=%h want=0000", timeBcd);
    end
    applyStimulus(BTN_START);
    applyTick();
    checkCount++;
    if (bus.state !== S_IDLE || timeBcd !== 16'h0000) begin
      errorCount++;
      $display("[TB] FAIL start_zero got st=%0d time=%h want 0/0000", bus.state, timeBcd);
    end
  endtask

  task automatic test_door_pause();
    applyStimulus(BTN_MIN);
    applyStimulus(BTN_START);
    checkCount++;
    if (bus.state !== S_COOK || timeBcd !== 16'h0100) begin
      errorCount++;
      $display("[TB] FAIL door_setup got st=%0d time=%h want 1/0100", bus.state, timeBcd);
    end
    @(negedge clock_in);
    bus.door_open = 1'b1;
    #1;
    checkCount++;
    if (bus.magnetron_on !== 1'b0 || bus.lamp_on !== 1'b1 || bus.state !== S_COOK) begin
      errorCount++;
      $display("[TB] FAIL door_cutoff got mag=%b lamp=%b st=%0d want 0/1/1",
               bus.magnetron_on, bus.lamp_on, bus.state);
    end
    @(negedge clock_in);
    checkCount++;
    if (bus.state !== S_PAUSE) begin
      errorCount++;
      $display("[TB] FAIL door_pause got=%0d want=%0d", bus.state, S_PAUSE);
    end
    repeat (5) applyTick();
    checkCount++;
    if (bus.state !== S_PAUSE || timeBcd !== 16'h0100) begin
      errorCount++;
      $display("[TB] FAIL door_frozen got st=%0d time=%h want 2/0100", bus.state, timeBcd);
    end
    bus.door_open = 1'b0;
    applyStimulus(BTN_START);
    checkCount++;
    if (bus.state !== S_COOK || bus.magnetron_on !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL resume got st=%0d mag=%b want 1/1", bus.state, bus.magnetron_on);
    end
    applyTick();
    checkCount++;
    if (timeBcd !== 16'h0059) begin
      errorCount++;
      $display("[TB] FAIL resume_tick got=%h want=0059", timeBcd);
    end
    applyStimulus(BTN_CANCEL);
    applyStimulus(BTN_CANCEL);
  endtask

  task automatic test_cancel();
    repeat (5) applyStimulus(BTN_10S);
    applyStimulus(BTN_START);
    repeat (5) applyTick();
    checkCount++;
    if (timeBcd !== 16'h0045 || bus.state !== S_COOK) begin
      errorCount++;
      $display("[TB] FAIL cancel_setup got st=%0d time=%h want 1/0045", bus.state, timeBcd);
    end
    applyStimulus(BTN_CANCEL);
    checkCount++;
    if (bus.state !== S_PAUSE || timeBcd !== 16'h0045) begin
      errorCount++;
      $display("[TB] FAIL cancel_pause got st=%0d time=%h want 2/0045", bus.state, timeBcd);
    end
    applyStimulus(BTN_CANCEL);
    checkCount++;
    if (bus.state !== S_IDLE || timeBcd !== 16'h0000) begin
      errorCount++;
      $display("[TB] FAIL cancel_idle got st=%0d time=%h want 0/0000", bus.state, timeBcd);
    end
    bus.door_open = 1'b1;
    applyStimulus(BTN_MIN);
    applyStimulus(BTN_START);
    checkCount++;
    if (bus.state !== S_IDLE || timeBcd !== 16'h0100) begin
      errorCount++;
      $display("[TB] FAIL start_door_open got st=%0d time=%h want 0/0100", bus.state, timeBcd);
    end
    bus.door_open = 1'b0;
    applyStimulus(BTN_CANCEL);
  endtask

  task automatic test_collisions();
    repeat (3) applyStimulus(BTN_10S);
    applyStimulus(BTN_START);
    repeat (10) applyTick();
    checkCount++;
    if (timeBcd !== 16'h0020) begin
      errorCount++;
      $display("[TB] FAIL coll_setup got=%h want=0020", timeBcd);
    end
    applyTickWithButton(BTN_10S);
    checkCount++;
    if (timeBcd !== 16'h0030 || bus.state !== S_COOK) begin
      errorCount++;
      $display("[TB] FAIL add_beats_tick got st=%0d time=%h want 1/0030", bus.state, timeBcd);
    end
    applyTickWithButton(BTN_CANCEL);
    checkCount++;
    if (timeBcd !== 16'h0030 || bus.state !== S_PAUSE) begin
      errorCount++;
      $display("[TB] FAIL cancel_beats_tick got st=%0d time=%h want 2/0030", bus.state, timeBcd);
    end
    applyStimulus(BTN_CANCEL);
  endtask

  task automatic test_async_reset();
    repeat (2) applyStimulus(BTN_MIN);
    repeat (2) applyStimulus(BTN_10S);
    applyStimulus(BTN_START);
    repeat (7) applyTick();
    checkCount++;
    if (timeBcd !== 16'h0213 || bus.state !== S_COOK) begin
      errorCount++;
      $display("[TB] FAIL rst_setup got st=%0d time=%h want 1/0213", bus.state, timeBcd);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checkCount++;
    if (bus.state !== S_IDLE || timeBcd !== 16'h0000 || bus.magnetron_on !== 1'b0 || bus.buzzer !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL async_reset got st=%0d time=%h mag=%b buz=%b want 0/0000/0/0",
               bus.state, timeBcd, bus.magnetron_on, bus.buzzer);
    end
    @(negedge clock_in);
    reset_n = 1'b1;
    repeat (2) applyTick();
    checkCount++;
    if (bus.state !== S_IDLE || timeBcd !== 16'h0000) begin
      errorCount++;
      $display("[TB] FAIL no_resume got st=%0d time=%h want 0/0000", bus.state, timeBcd);
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    checkCount      = 0;
    errorCount      = 0;
    reset_n         = 1'b0;
    bus.tick_in     = 1'b0;
    bus.btn_add_min = 1'b0;
    bus.btn_add_10s = 1'b0;
    bus.btn_start   = 1'b0;
    bus.btn_cancel  = 1'b0;
    bus.door_open   = 1'b0;
    test_reset();
    test_countdown();
    test_bcd_limits();
    test_door_pause();
    test_cancel();
    test_collisions();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
